// File: rtl/onchip_mem_block_reader_if.sv
// Bus bundle for the block reader: Avalon-MM read port toward the on-chip RAM
// and the outgoing valid/ready word stream.
interface onchip_mem_block_reader_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic              m_clken;
    logic [31:0]       m_readdata;
    logic [31:0]       st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_last;

    modport master (
        output m_address, m_chipselect, m_write, m_byteenable, m_clken,
        input  m_readdata,
        output st_data, st_valid, st_last,
        input  st_ready
    );

    modport slave (
        input  m_address, m_chipselect, m_write, m_byteenable, m_clken,
        output m_readdata,
        input  st_data, st_valid, st_last,
        output st_ready
    );
endinterface

// File: rtl/onchip_mem_block_reader.sv
// Drains a contiguous block of 32-bit words from a 1-cycle-latency on-chip RAM
// and replays it as a valid/ready stream with a last-word flag.
module onchip_mem_block_reader #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    onchip_mem_block_reader_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0]  MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [OCC_W:0]   DEPTH_LIM = (OCC_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              cs_reg;
    logic              cs_last_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] next_addr_reg;
    logic [ADDR_W:0]   left_reg;

    logic              rdv_reg;
    logic              rdv_last_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [OCC_W-1:0]  occ_reg;
    logic [OCC_W-1:0]  occ_next;

    logic [32:0]       fifo_mem [FIFO_DEPTH];
    logic [32:0]       head;
    logic              push;
    logic              pop;
    logic              room;
    logic [ADDR_W:0]   count_clamped;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

    assign push = rdv_reg;
    assign pop  = bus.st_valid & bus.st_ready;

    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + 1'b1;
            2'b01:   occ_next = occ_reg - 1'b1;
            default: occ_next = occ_reg;
        endcase
    end

    // The strobe being registered now returns two edges later; the read that is
    // currently strobed is the one that will be in flight next cycle. The pop of
    // the upcoming cycle is deliberately not credited.
    assign room = ({1'b0, occ_next} + {{OCC_W{1'b0}}, cs_reg}) < DEPTH_LIM;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cs_reg        <= 1'b0;
            cs_last_reg   <= 1'b0;
            addr_reg      <= '0;
            next_addr_reg <= '0;
            left_reg      <= '0;
        end else begin
            cs_reg      <= 1'b0;
            cs_last_reg <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (count_clamped == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            cs_reg        <= 1'b1;
                            cs_last_reg   <= (count_clamped == ONE_WORD);
                            addr_reg      <= base_addr;
                            next_addr_reg <= base_addr + 1'b1;
                            left_reg      <= count_clamped - 1'b1;
                            state_reg     <= (count_clamped == ONE_WORD) ? S_DRAIN : S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (room) begin
                        cs_reg        <= 1'b1;
                        cs_last_reg   <= (left_reg == ONE_WORD);
                        addr_reg      <= next_addr_reg;
                        next_addr_reg <= next_addr_reg + 1'b1;
                        left_reg      <= left_reg - 1'b1;
                        if (left_reg == ONE_WORD) begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (occ_reg == '0 && !rdv_reg && !cs_reg) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Read-return pipeline and FIFO bookkeeping; reset drops any in-flight word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdv_reg      <= 1'b0;
            rdv_last_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
        end else begin
            rdv_reg      <= cs_reg;
            rdv_last_reg <= cs_last_reg;
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            occ_reg <= occ_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [32:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push && wr_ptr_reg == PTR_W'(gi)) begin
                    entry_reg <= {rdv_last_reg, bus.m_readdata};
                end
            end
            assign fifo_mem[gi] = entry_reg;
        end
    endgenerate

    assign head = fifo_mem[rd_ptr_reg];

    // Storage is not reset, so the stream fields are gated to read zero when empty.
    assign bus.st_valid = (occ_reg != '0);
    assign bus.st_data  = bus.st_valid ? head[31:0] : 32'h0;
    assign bus.st_last  = bus.st_valid & head[32];

    assign bus.m_address    = addr_reg;
    assign bus.m_chipselect = cs_reg;
    assign bus.m_write      = 1'b0;
    assign bus.m_byteenable = 4'hF;
    assign bus.m_clken      = 1'b1;

    assign busy = busy_reg;
    assign done = done_reg;
endmodule

// File: tb/tb_onchip_mem_block_reader.sv
// Directed bench for onchip_mem_block_reader: RAM model, stream monitor and
// hand-computed expectations for timing, ordering, wrap, backpressure and reset.
module tb_onchip_mem_block_reader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] word_count = '0;
    logic        busy;
    logic        done;

    onchip_mem_block_reader_if #(.ADDR_W(10)) bus ();

    onchip_mem_block_reader #(.ADDR_W(10), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (bus.m_chipselect) bus.m_readdata <= ram[bus.m_address];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream/bus monitor: samples pre-edge values on every rising edge.
    logic [31:0] got_data [$];
    logic        got_last [$];
    logic [9:0]  got_addr [$];
    int          outstanding = 0;
    int          max_outstanding = 0;
    int          stall_err = 0;
    logic        hold_valid = 1'b0;
    logic [32:0] hold_word = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding = 0;
            hold_valid  = 1'b0;
        end else begin
            if (bus.m_chipselect) begin
                got_addr.push_back(bus.m_address);
                outstanding++;
            end
            if (hold_valid && (!bus.st_valid || {bus.st_last, bus.st_data} != hold_word)) stall_err++;
            if (bus.st_valid && bus.st_ready) begin
                got_data.push_back(bus.st_data);
                got_last.push_back(bus.st_last);
                outstanding--;
            end
            hold_valid = bus.st_valid && !bus.st_ready;
            hold_word  = {bus.st_last, bus.st_data};
            if (outstanding > max_outstanding) max_outstanding = outstanding;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a block, then walks cycle by cycle (cycle 1 = first cycle after the
    // start edge) until done. stall=k means st_ready high one cycle in k+1.
    task automatic run_block(input logic [9:0] b, input logic [10:0] n, input int stall,
                             input int restart_at, output int done_cyc, output int first_valid);
        int cyc;
        got_data.delete();
        got_last.delete();
        got_addr.delete();
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        tick();
        start       = 1'b0;
        cyc         = 1;
        done_cyc    = -1;
        first_valid = -1;
        while (done_cyc < 0 && cyc < 3000) begin
            bus.st_ready = (stall == 0) || ((cyc % (stall + 1)) == 0);
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                base_addr  = 10'd0;
                word_count = 11'd2;
            end
            if (first_valid < 0 && bus.st_valid) first_valid = cyc;
            if (done) done_cyc = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        start        = 1'b0;
        bus.st_ready = 1'b1;
        check("block_timeout", 64'(done_cyc >= 0), 64'd1);
        tick();
    endtask

    function automatic logic [63:0] exp_word(input int b, input int n, input int i);
        return {31'b0, (i == n - 1), 32'h1000_0000 + 32'((b + i) % 1024)};
    endfunction

    task automatic verify_block(input string tag, input int b, input int n);
        check({tag, "_nwords"}, 64'(got_data.size()), 64'(n));
        check({tag, "_nreads"}, 64'(got_addr.size()), 64'(n));
        for (int i = 0; i < n && i < got_data.size(); i++)
            check($sformatf("%s_word%0d", tag, i), {31'b0, got_last[i], got_data[i]}, exp_word(b, n, i));
        for (int i = 0; i < n && i < got_addr.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'((b + i) % 1024));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_valid"}, 64'(bus.st_valid), 64'd0);
        check({tag, "_last"}, 64'(bus.st_last), 64'd0);
        check({tag, "_data"}, 64'(bus.st_data), 64'd0);
        check({tag, "_cs"}, 64'(bus.m_chipselect), 64'd0);
        check({tag, "_addr"}, 64'(bus.m_address), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        int fv;
        int cnt;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h1000_0000 + i;
        bus.st_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_write", 64'(bus.m_write), 64'd0);
        check("reset_be", 64'(bus.m_byteenable), 64'hF);
        check("reset_clken", 64'(bus.m_clken), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Basic 8-word block
        run_block(10'd0, 11'd8, 0, -1, dc, fv);
        $display("basic: done_cycle=%0d first_valid=%0d words=%0d", dc, fv, got_data.size());
        check("basic_done_cycle", 64'(dc), 64'd12);
        check("basic_first_valid", 64'(fv), 64'd3);
        verify_block("basic", 0, 8);
        check("basic_busy_after", 64'(busy), 64'd0);

        // Address wrap
        run_block(10'd1022, 11'd4, 0, -1, dc, fv);
        $display("wrap: done_cycle=%0d words=%0d", dc, got_data.size());
        check("wrap_done_cycle", 64'(dc), 64'd8);
        verify_block("wrap", 1022, 4);

        // Backpressure 1 on / 3 off
        stall_err = 0;
        max_outstanding = 0;
        run_block(10'd100, 11'd16, 3, -1, dc, fv);
        $display("backpressure: done_cycle=%0d words=%0d max_out=%0d", dc, got_data.size(), max_outstanding);
        verify_block("bp", 100, 16);
        check("bp_stall_stable", 64'(stall_err), 64'd0);
        check("bp_max_outstanding", 64'(max_outstanding), 64'd4);

        // Zero count
        run_block(10'd7, 11'd0, 0, -1, dc, fv);
        $display("zero: done_cycle=%0d reads=%0d", dc, got_addr.size());
        check("zero_done_cycle", 64'(dc), 64'd1);
        verify_block("zero", 7, 0);

        // Oversize count clamps to 1024 words, last at base-1
        run_block(10'd5, 11'd2047, 0, -1, dc, fv);
        $display("oversize: done_cycle=%0d words=%0d", dc, got_data.size());
        check("over_done_cycle", 64'(dc), 64'd1028);
        verify_block("over", 5, 1024);

        // Reset after 5 words of a 20-word block
        got_data.delete();
        got_last.delete();
        got_addr.delete();
        base_addr  = 10'd200;
        word_count = 11'd20;
        start      = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 0;
        while (got_data.size() < 5 && cnt < 50) begin
            tick();
            cnt++;
        end
        check("rst_five_words", 64'(got_data.size()), 64'd5);
        check("rst_busy_before", 64'(busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        $display("midreset: outputs after reset busy=%0b valid=%0b cs=%0b", busy, bus.st_valid, bus.m_chipselect);
        check_idle_outputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        run_block(10'd50, 11'd3, 0, -1, dc, fv);
        $display("after_reset: done_cycle=%0d words=%0d", dc, got_data.size());
        check("post_rst_done_cycle", 64'(dc), 64'd7);
        verify_block("post_rst", 50, 3);

        // Second start while busy is ignored
        run_block(10'd300, 11'd6, 0, 3, dc, fv);
        $display("start_busy: done_cycle=%0d words=%0d", dc, got_data.size());
        check("sb_done_cycle", 64'(dc), 64'd10);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) cnt++;
            tick();
        end
        check("sb_extra_done", 64'(cnt), 64'd0);
        verify_block("sb", 300, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
